// File: rtl/dtag_ram_nway_if.sv
// Bundle of request/response signals for the N-way data-cache tag store.
// Slave modport is the tag store side; master modport is the cache controller side.
interface dtag_ram_nway_if #(
  parameter int WAYS     = 4,
  parameter int INDEX_W  = 8,
  parameter int TAG_W    = 21,
  parameter int THREAD_W = 2
) ();
  localparam int WAY_W = $clog2(WAYS);

  logic                      rd_en;
  logic [INDEX_W-1:0]        rd_index;
  logic                      hit_en;
  logic [INDEX_W-1:0]        hit_index;
  logic [WAY_W-1:0]          hit_way;
  logic                      l2_we;
  logic [INDEX_W-1:0]        l2_index;
  logic [WAY_W-1:0]          l2_way;
  logic [TAG_W-1:0]          l2_tag;
  logic [THREAD_W-1:0]       l2_thread;
  logic                      mem_we;
  logic [INDEX_W-1:0]        mem_index;
  logic [WAY_W-1:0]          mem_way;
  logic [TAG_W-1:0]          mem_tag;
  logic [THREAD_W-1:0]       mem_thread;
  logic                      dc_we;
  logic [INDEX_W-1:0]        dc_index;
  logic [WAY_W-1:0]          dc_way;
  logic [TAG_W-1:0]          dc_tag;
  logic [THREAD_W-1:0]       dc_thread;
  logic [WAYS*TAG_W-1:0]     tag_rd;
  logic [WAYS*THREAD_W-1:0]  thread_rd;
  logic [WAYS-1:0]           valid_rd;
  logic [WAYS-1:0]           dirty_rd;
  logic [WAY_W-1:0]          victim_way;
  logic                      init_busy;
  logic                      w_complete_l2;
  logic                      w_complete_mem;
  logic                      w_complete_dc;

  modport slave (
    input  rd_en, rd_index, hit_en, hit_index, hit_way,
    input  l2_we, l2_index, l2_way, l2_tag, l2_thread,
    input  mem_we, mem_index, mem_way, mem_tag, mem_thread,
    input  dc_we, dc_index, dc_way, dc_tag, dc_thread,
    output tag_rd, thread_rd, valid_rd, dirty_rd, victim_way,
    output init_busy, w_complete_l2, w_complete_mem, w_complete_dc
  );

  modport master (
    output rd_en, rd_index, hit_en, hit_index, hit_way,
    output l2_we, l2_index, l2_way, l2_tag, l2_thread,
    output mem_we, mem_index, mem_way, mem_tag, mem_thread,
    output dc_we, dc_index, dc_way, dc_tag, dc_thread,
    input  tag_rd, thread_rd, valid_rd, dirty_rd, victim_way,
    input  init_busy, w_complete_l2, w_complete_mem, w_complete_dc
  );
endinterface

// File: rtl/dtag_ram_nway.sv
// N-way tag store with tree pseudo-LRU, fixed-priority write arbitration and a post-reset invalidation sweep.
// Optional macro DTAG_WR_BYPASS_EN forwards a same-cycle write into the read result.
module dtag_ram_nway #(
  parameter int WAYS     = 4,
  parameter int INDEX_W  = 8,
  parameter int TAG_W    = 21,
  parameter int THREAD_W = 2
) (
  input logic            clk,
  input logic            reset,
  dtag_ram_nway_if.slave bus
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int PLRU_W = WAYS - 1;
  localparam int DEPTH  = 2 ** INDEX_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, next_state;
  logic               busy, busy_next;
  logic [INDEX_W-1:0] sweep_idx, sweep_idx_next;
  logic               sweep_en;
  logic               run;

  logic               wr_go;
  logic [2:0]         wr_src;
  logic [INDEX_W-1:0] wr_index;
  logic [WAY_W-1:0]   wr_way;
  logic [TAG_W-1:0]   wr_tag;
  logic [THREAD_W-1:0] wr_thread;
  logic               wr_dirty;

  logic [TAG_W-1:0]    tag_mem    [DEPTH][WAYS];
  logic [THREAD_W-1:0] thread_mem [DEPTH][WAYS];
  logic [WAYS-1:0]     valid_mem  [DEPTH];
  logic [WAYS-1:0]     dirty_mem  [DEPTH];
  logic [PLRU_W-1:0]   plru_mem   [DEPTH];

  logic [WAYS-1:0][TAG_W-1:0]    rd_tag_c, tag_q;
  logic [WAYS-1:0][THREAD_W-1:0] rd_thread_c, thread_q;
  logic [WAYS-1:0]               rd_valid_c, rd_dirty_c, valid_q, dirty_q;
  logic [PLRU_W-1:0]             rd_plru_c;
  logic [WAY_W-1:0]              victim_q;
  logic [2:0]                    done_q;

  // Point every tree node on the path to 'way' away from it, making it most-recently-used.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] cur,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] res;
    res = cur;
    for (int lvl = 0; lvl < WAY_W; lvl++)
      for (int k = 0; k < (1 << lvl); k++)
        if (int'(way >> (WAY_W - lvl)) == k)
          res[(1 << lvl) - 1 + k] = ~way[WAY_W-1-lvl];
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] victim_of(input logic [WAYS-1:0]   valid,
                                                 input logic [PLRU_W-1:0] plru);
    int               p;
    logic             b;
    logic [WAY_W-1:0] res;
    p = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b = 1'b0;
      for (int k = 0; k < (1 << lvl); k++)
        if (p == k) b = plru[(1 << lvl) - 1 + k];
      p = (p << 1) + int'(b);
    end
    res = WAY_W'(p);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[w]) res = WAY_W'(w);
    return res;
  endfunction

  // init_busy rises one edge after reset release, then one set is cleared per cycle.
  always_comb begin
    next_state     = state;
    busy_next      = busy;
    sweep_idx_next = sweep_idx;
    sweep_en       = 1'b0;
    case (state)
      INIT: begin
        busy_next = 1'b1;
        if (busy) begin
          sweep_en       = 1'b1;
          sweep_idx_next = sweep_idx + 1'b1;
          if (sweep_idx == '1) begin
            next_state = RUN;
            busy_next  = 1'b0;
          end
        end
      end
      RUN:     busy_next  = 1'b0;
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      busy      <= 1'b0;
      sweep_idx <= '0;
    end else begin
      state     <= next_state;
      busy      <= busy_next;
      sweep_idx <= sweep_idx_next;
    end
  end

  assign run = (state == RUN);

  always_comb begin
    wr_go     = 1'b0;
    wr_src    = 3'b000;
    wr_index  = '0;
    wr_way    = '0;
    wr_tag    = '0;
    wr_thread = '0;
    wr_dirty  = 1'b0;
    if (run) begin
      if (bus.l2_we) begin
        wr_go = 1'b1; wr_src = 3'b100;
        wr_index = bus.l2_index; wr_way = bus.l2_way;
        wr_tag = bus.l2_tag; wr_thread = bus.l2_thread;
      end else if (bus.mem_we) begin
        wr_go = 1'b1; wr_src = 3'b010;
        wr_index = bus.mem_index; wr_way = bus.mem_way;
        wr_tag = bus.mem_tag; wr_thread = bus.mem_thread;
      end else if (bus.dc_we) begin
        wr_go = 1'b1; wr_src = 3'b001; wr_dirty = 1'b1;
        wr_index = bus.dc_index; wr_way = bus.dc_way;
        wr_tag = bus.dc_tag; wr_thread = bus.dc_thread;
      end
    end
  end

  // Write touch is issued after the hit touch so it wins when both address the same set.
  always_ff @(posedge clk) begin
    if (sweep_en) begin
      valid_mem[sweep_idx] <= '0;
      dirty_mem[sweep_idx] <= '0;
      plru_mem[sweep_idx]  <= '0;
    end else begin
      if (run && bus.hit_en)
        plru_mem[bus.hit_index] <= plru_touch(plru_mem[bus.hit_index], bus.hit_way);
      if (wr_go) begin
        tag_mem[wr_index][wr_way]    <= wr_tag;
        thread_mem[wr_index][wr_way] <= wr_thread;
        valid_mem[wr_index][wr_way]  <= 1'b1;
        dirty_mem[wr_index][wr_way]  <= wr_dirty;
        plru_mem[wr_index]           <= plru_touch(plru_mem[wr_index], wr_way);
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_tag_c[w]    = tag_mem[bus.rd_index][w];
      rd_thread_c[w] = thread_mem[bus.rd_index][w];
    end
    rd_valid_c = valid_mem[bus.rd_index];
    rd_dirty_c = dirty_mem[bus.rd_index];
    rd_plru_c  = plru_mem[bus.rd_index];
`ifdef DTAG_WR_BYPASS_EN
    if (wr_go && (wr_index == bus.rd_index)) begin
      rd_tag_c[wr_way]    = wr_tag;
      rd_thread_c[wr_way] = wr_thread;
      rd_valid_c[wr_way]  = 1'b1;
      rd_dirty_c[wr_way]  = wr_dirty;
      rd_plru_c           = plru_touch(rd_plru_c, wr_way);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q    <= '0;
      thread_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      victim_q <= '0;
      done_q   <= '0;
    end else begin
      done_q <= wr_src;
      if (run && bus.rd_en) begin
        tag_q    <= rd_tag_c;
        thread_q <= rd_thread_c;
        valid_q  <= rd_valid_c;
        dirty_q  <= rd_dirty_c;
        victim_q <= victim_of(rd_valid_c, rd_plru_c);
      end
    end
  end

  assign bus.tag_rd         = tag_q;
  assign bus.thread_rd      = thread_q;
  assign bus.valid_rd       = valid_q;
  assign bus.dirty_rd       = dirty_q;
  assign bus.victim_way     = victim_q;
  assign bus.init_busy      = busy;
  assign bus.w_complete_l2  = done_q[2];
  assign bus.w_complete_mem = done_q[1];
  assign bus.w_complete_dc  = done_q[0];
endmodule

// File: tb/tb_dtag_ram_nway.sv
// Self-checking bench for dtag_ram_nway: directed write/read vector table plus hand sequences
// for sweep length, arbitration order, PLRU hit update, read/write collision and mid-sweep reset.
module tb_dtag_ram_nway;
  localparam int WAYS     = 4;
  localparam int INDEX_W  = 8;
  localparam int TAG_W    = 21;
  localparam int THREAD_W = 2;
  localparam int WAY_W    = 2;
  localparam int DEPTH    = 256;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dtag_ram_nway_if #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .THREAD_W(THREAD_W)) bus ();

  dtag_ram_nway #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .THREAD_W(THREAD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]          src;
    logic [INDEX_W-1:0]  index;
    logic [WAY_W-1:0]    way;
    logic [TAG_W-1:0]    tag;
    logic [THREAD_W-1:0] thread;
    logic [WAYS-1:0]     exp_valid;
    logic [WAYS-1:0]     exp_dirty;
    logic [WAY_W-1:0]    exp_victim;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_en = 1'b0;  bus.rd_index = '0;
    bus.hit_en = 1'b0; bus.hit_index = '0; bus.hit_way = '0;
    bus.l2_we = 1'b0;  bus.l2_index = '0;  bus.l2_way = '0;  bus.l2_tag = '0;  bus.l2_thread = '0;
    bus.mem_we = 1'b0; bus.mem_index = '0; bus.mem_way = '0; bus.mem_tag = '0; bus.mem_thread = '0;
    bus.dc_we = 1'b0;  bus.dc_index = '0;  bus.dc_way = '0;  bus.dc_tag = '0;  bus.dc_thread = '0;
  endtask

  function automatic logic [2:0] pulses();
    return {bus.w_complete_l2, bus.w_complete_mem, bus.w_complete_dc};
  endfunction

  task automatic read_set(input logic [INDEX_W-1:0] idx);
    bus.rd_en = 1'b1; bus.rd_index = idx;
    step();
    bus.rd_en = 1'b0;
  endtask

  // Counts samples with init_busy high after reset release; optionally drives requests that must be ignored.
  task automatic count_sweep(input bit noise, output int n, output logic [4:0] leak);
    bit rose;
    n = 0; rose = 0; leak = '0;
    if (noise) begin
      bus.l2_we = 1'b1; bus.l2_index = 8'd5; bus.l2_way = 2'd0; bus.l2_tag = 21'h1;
      bus.dc_we = 1'b1; bus.dc_index = 8'd6; bus.dc_way = 2'd1;
      bus.rd_en = 1'b1; bus.rd_index = 8'd5;
    end
    for (int c = 0; c < 400; c++) begin
      step();
      leak = leak | {pulses(), |bus.valid_rd, |bus.dirty_rd};
      if (bus.init_busy) begin
        n++; rose = 1;
      end else if (rose) begin
        break;
      end
    end
    idle_inputs();
  endtask

  task automatic applyStimulus(input vec_t v, output logic [2:0] p_commit, output logic [2:0] p_after);
    case (v.src)
      2'd0: begin bus.l2_we = 1'b1; bus.l2_index = v.index; bus.l2_way = v.way;
                  bus.l2_tag = v.tag; bus.l2_thread = v.thread; end
      2'd1: begin bus.mem_we = 1'b1; bus.mem_index = v.index; bus.mem_way = v.way;
                  bus.mem_tag = v.tag; bus.mem_thread = v.thread; end
      default: begin bus.dc_we = 1'b1; bus.dc_index = v.index; bus.dc_way = v.way;
                  bus.dc_tag = v.tag; bus.dc_thread = v.thread; end
    endcase
    step();
    p_commit = pulses();
    bus.l2_we = 1'b0; bus.mem_we = 1'b0; bus.dc_we = 1'b0;
    read_set(v.index);
    p_after = pulses();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         n;
    logic [4:0] leak;
    logic [2:0] pc, pa;
    logic [2:0] exp_arb [3];

    vecs[0] = '{2'd0, 8'd3,   2'd2, 21'h1ABCD,  2'd1, 4'b0100, 4'b0000, 2'd0};
    vecs[1] = '{2'd1, 8'd3,   2'd0, 21'h00055,  2'd2, 4'b0101, 4'b0000, 2'd1};
    vecs[2] = '{2'd2, 8'd3,   2'd1, 21'h1FFFFF, 2'd3, 4'b0111, 4'b0010, 2'd3};
    vecs[3] = '{2'd2, 8'd3,   2'd3, 21'h00001,  2'd0, 4'b1111, 4'b1010, 2'd0};
    vecs[4] = '{2'd0, 8'd255, 2'd3, 21'h12345,  2'd2, 4'b1000, 4'b0000, 2'd0};
    vecs[5] = '{2'd1, 8'd0,   2'd1, 21'h00000,  2'd0, 4'b0010, 4'b0000, 2'd0};
    vecs[6] = '{2'd0, 8'd3,   2'd0, 21'h0AAAA,  2'd1, 4'b1111, 4'b1010, 2'd2};
    vecs[7] = '{2'd2, 8'd3,   2'd2, 21'h0BBBB,  2'd2, 4'b1111, 4'b1110, 2'd1};

    reset = 1'b1;
    idle_inputs();
    repeat (3) step();
    checkOutput("rst_init_busy", 64'(bus.init_busy), 64'd0);
    checkOutput("rst_valid",     64'(bus.valid_rd),  64'd0);
    checkOutput("rst_tag",       64'(bus.tag_rd),    64'd0);
    checkOutput("rst_victim",    64'(bus.victim_way), 64'd0);
    checkOutput("rst_pulses",    64'(pulses()),      64'd0);
    reset = 1'b0;

    count_sweep(1'b1, n, leak);
    checkOutput("sweep_len", 64'(n), 64'(DEPTH));
    checkOutput("init_ignores_requests", 64'(leak), 64'd0);

    read_set(8'd5);
    checkOutput("set5_valid",  64'(bus.valid_rd),   64'd0);
    checkOutput("set5_dirty",  64'(bus.dirty_rd),   64'd0);
    checkOutput("set5_victim", 64'(bus.victim_way), 64'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], pc, pa);
      checkOutput($sformatf("vec%0d_pulse", i), 64'(pc), 64'(3'b100 >> vecs[i].src));
      checkOutput($sformatf("vec%0d_pulse_end", i), 64'(pa), 64'd0);
      checkOutput($sformatf("vec%0d_valid", i), 64'(bus.valid_rd), 64'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_dirty", i), 64'(bus.dirty_rd), 64'(vecs[i].exp_dirty));
      checkOutput($sformatf("vec%0d_victim", i), 64'(bus.victim_way), 64'(vecs[i].exp_victim));
      checkOutput($sformatf("vec%0d_tag", i), 64'(bus.tag_rd[vecs[i].way*TAG_W +: TAG_W]), 64'(vecs[i].tag));
      checkOutput($sformatf("vec%0d_thread", i),
                  64'(bus.thread_rd[vecs[i].way*THREAD_W +: THREAD_W]), 64'(vecs[i].thread));
    end

    // Three simultaneous writers, each dropping its request once acknowledged.
    exp_arb[0] = 3'b100; exp_arb[1] = 3'b010; exp_arb[2] = 3'b001;
    bus.l2_we  = 1'b1; bus.l2_index  = 8'd20; bus.l2_way  = 2'd0; bus.l2_tag  = 21'h111;
    bus.mem_we = 1'b1; bus.mem_index = 8'd20; bus.mem_way = 2'd1; bus.mem_tag = 21'h222;
    bus.dc_we  = 1'b1; bus.dc_index  = 8'd20; bus.dc_way  = 2'd2; bus.dc_tag  = 21'h333;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("arb_cycle%0d", i), 64'(pulses()), 64'(exp_arb[i]));
      if (bus.w_complete_l2)  bus.l2_we  = 1'b0;
      if (bus.w_complete_mem) bus.mem_we = 1'b0;
      if (bus.w_complete_dc)  bus.dc_we  = 1'b0;
    end
    idle_inputs();
    read_set(8'd20);
    checkOutput("arb_valid",  64'(bus.valid_rd),   64'b0111);
    checkOutput("arb_dirty",  64'(bus.dirty_rd),   64'b0100);
    checkOutput("arb_victim", 64'(bus.victim_way), 64'd3);
    checkOutput("arb_tag1",   64'(bus.tag_rd[1*TAG_W +: TAG_W]), 64'h222);

    for (int w = 0; w < WAYS; w++) begin
      bus.l2_we = 1'b1; bus.l2_index = 8'd7; bus.l2_way = WAY_W'(w); bus.l2_tag = TAG_W'(w + 16);
      step();
    end
    bus.l2_we = 1'b0;
    read_set(8'd7);
    checkOutput("set7_valid",  64'(bus.valid_rd),   64'b1111);
    checkOutput("set7_victim", 64'(bus.victim_way), 64'd0);
    bus.hit_en = 1'b1; bus.hit_index = 8'd7; bus.hit_way = 2'd0;
    step();
    bus.hit_en = 1'b0;
    read_set(8'd7);
    checkOutput("set7_hit_victim", 64'(bus.victim_way), 64'd2);

    bus.l2_we = 1'b1; bus.l2_index = 8'd9; bus.l2_way = 2'd1; bus.l2_tag = 21'h777; bus.l2_thread = 2'd1;
    step();
    bus.l2_we = 1'b0;
    bus.dc_we = 1'b1; bus.dc_index = 8'd9; bus.dc_way = 2'd1; bus.dc_tag = 21'h888; bus.dc_thread = 2'd2;
    read_set(8'd9);
    bus.dc_we = 1'b0;
    checkOutput("coll_pulse", 64'(pulses()), 64'b001);
`ifdef DTAG_WR_BYPASS_EN
    checkOutput("coll_dirty", 64'(bus.dirty_rd[1]), 64'd1);
    checkOutput("coll_tag",   64'(bus.tag_rd[1*TAG_W +: TAG_W]), 64'h888);
`else
    checkOutput("coll_dirty", 64'(bus.dirty_rd[1]), 64'd0);
    checkOutput("coll_tag",   64'(bus.tag_rd[1*TAG_W +: TAG_W]), 64'h777);
`endif
    read_set(8'd9);
    checkOutput("coll_dirty_next", 64'(bus.dirty_rd[1]), 64'd1);
    checkOutput("coll_tag_next",   64'(bus.tag_rd[1*TAG_W +: TAG_W]), 64'h888);
    checkOutput("coll_thread_next", 64'(bus.thread_rd[1*THREAD_W +: THREAD_W]), 64'd2);

    // Interrupt a sweep partway through, then require a complete fresh sweep.
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 300 && n < 100; c++) begin
      step();
      if (bus.init_busy) n++;
    end
    checkOutput("midsweep_reached", 64'(n), 64'd100);
    reset = 1'b1;
    step();
    checkOutput("midsweep_rst_busy", 64'(bus.init_busy), 64'd0);
    reset = 1'b0;
    count_sweep(1'b0, n, leak);
    checkOutput("midsweep_len", 64'(n), 64'(DEPTH));
    read_set(8'd255);
    checkOutput("resweep_set255_valid", 64'(bus.valid_rd), 64'd0);
    read_set(8'd3);
    checkOutput("resweep_set3_valid", 64'(bus.valid_rd), 64'd0);
    checkOutput("resweep_set3_dirty", 64'(bus.dirty_rd), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dtag_ram_nway.md
Name: dtag_ram_nway

Overview:
Parametrised N-way tag store for the multithreaded data cache. It holds per-set tag, thread ID, valid and dirty bits per way, plus a tree pseudo-LRU vector per set. Three write sources (L2 refill, memory refill, store-hit dirty update) are arbitrated by fixed priority. Reads are synchronous and report all ways plus a victim way. After reset, an internal sweep invalidates every set before the block accepts traffic.

Parameters:
WAYS, 4, number of ways; power of two, 2..8
INDEX_W, 8, set index width; DEPTH = 2**INDEX_W
TAG_W, 21, tag width
THREAD_W, 2, thread ID width
(derived) WAY_W = log2(WAYS); PLRU_W = WAYS-1

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
rd_en  in  1  read request
rd_index  in  INDEX_W  read set
hit_en  in  1  LRU touch for a way hit in the current cycle
hit_index  in  INDEX_W  set of the touch
hit_way  in  WAY_W  way of the touch
l2_we  in  1  refill-from-L2 write request
l2_index  in  INDEX_W  set for the L2 write
l2_way  in  WAY_W  way for the L2 write
l2_tag  in  TAG_W  tag for the L2 write
l2_thread  in  THREAD_W  thread for the L2 write
mem_we, mem_index, mem_way, mem_tag, mem_thread  in  as l2_*  refill-from-memory write
dc_we, dc_index, dc_way, dc_tag, dc_thread  in  as l2_*  store-hit write
tag_rd  out  WAYS*TAG_W  tags; way w at [w*TAG_W +: TAG_W]
thread_rd  out  WAYS*THREAD_W  thread IDs, packed the same way
valid_rd  out  WAYS  valid bits
dirty_rd  out  WAYS  dirty bits
victim_way  out  WAY_W  PLRU victim for the set read
init_busy  out  1  invalidation sweep in progress
w_complete_l2  out  1  one-cycle pulse: L2 write committed
w_complete_mem  out  1  one-cycle pulse: memory write committed
w_complete_dc  out  1  one-cycle pulse: store-hit write committed

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high.
- Reset values: all outputs 0. init_busy goes to 1 on the first clk edge after reset deasserts.
- FSM states: INIT, RUN.
  - INIT: a counter walks index 0..DEPTH-1, one set per cycle, clearing valid, dirty and PLRU for all ways. Tag and thread contents are don't-care.
  - After clearing index DEPTH-1, the FSM enters RUN and init_busy falls. Sweep length is exactly DEPTH cycles.
  - Asserting reset during INIT restarts the sweep from index 0.
- During INIT: all requests are ignored, no w_complete pulses, read outputs hold 0.
- Write arbitration: priority l2 > mem > dc. One write per cycle.
  - Granted source: its w_complete_* pulses the next cycle.
  - Losing sources get no pulse and must hold their request until they see their pulse.
- L2/memory write: stores tag and thread, valid=1, dirty=0.
- dc write: stores tag and thread, valid=1, dirty=1.
- All writes set the PLRU of that set so the written way becomes most-recently-used.
- Read: rd_en at cycle N means all *_rd outputs and victim_way are valid at N+1 and held until the next rd_en.
- victim_way:
  - If any way in the set is invalid, victim_way is the lowest-numbered invalid way.
  - Otherwise, victim_way follows the PLRU tree (bit 0 = root; bit value 0 points to the lower half).
- hit_en: updates PLRU toward hit_way. If a write targets the same set in the same cycle, the write's PLRU update wins.
- Read/write collision (same set, same cycle): read returns pre-write contents (read-first).
- Two sources targeting the same set and way: only the winner commits; losers retry later.

Optional Feature:
DTAG_WR_BYPASS_EN
- Defined: on a read/write collision at the same set, the written way's tag, thread, valid and dirty are forwarded into the read result. victim_way reflects the post-write PLRU.
- Undefined: read-first behaviour as above.

Test Plan:
- Reset, then count cycles -> init_busy high for exactly 256 cycles (INIT_W=8); rd_en on set 5 after the sweep -> valid_rd=0, dirty_rd=0, victim_way=0.
- l2_we on set 3, way 2, tag 0x1ABCD, thread 1; rd_en on set 3 -> tag way 2 = 0x1ABCD, thread 1, valid_rd=4'b0100, dirty_rd=0; w_complete_l2 pulses one cycle.
- l2_we, mem_we and dc_we in the same cycle, each held until acknowledged -> pulses in order l2, mem, dc over 3 consecutive cycles.
- Fill all 4 ways of set 7 in order 0,1,2,3 -> victim_way=0; hit_en on way 0, then read -> victim_way=2.
- rd_en and dc_we on set 9, way 1 in the same cycle -> dirty_rd[1]=0 without DTAG_WR_BYPASS_EN, 1 with it; the next read shows 1 in both builds.
- Assert reset mid-sweep at index 100 -> after release, init_busy stays high for a full 256 cycles.
